// File: rtl/layer_cfg_sched.sv
// Layer scheduler: walks a host-written descriptor table once per frame and
// hands each layer's configuration to the guard controller over valid/ready/finish.
`timescale 1ns/1ps
module layer_cfg_sched #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [37:0]   cfg_wdata,
  input  logic          start,
  input  logic [AW:0]   num_layers_i,
  input  logic [7:0]    num_frames_i,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [AW-1:0] layer_cnt,
  output logic [7:0]    frame_cnt,
  output logic          ctrl_valid,
  input  logic          ctrl_ready,
  input  logic          ctrl_finish,
  output logic [7:0]    w_num_o,
  output logic [7:0]    h_num_o,
  output logic [7:0]    c_num_o,
  output logic [7:0]    co_num_o,
  output logic [3:0]    shift_bias_o,
  output logic          kernel_mode_o,
  output logic          is_diff_o,
  output logic          is_first_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [37:0]   desc_mem [DEPTH];
  logic [37:0]   rd_desc;
  logic [AW:0]   num_layers_q;
  logic [7:0]    num_frames_q;
  logic          abort_pending;
  logic          stop_req;
  logic          handshake;
  logic          last_layer;
  logic          last_frame;
  logic          zero_run;

  assign rd_desc    = desc_mem[layer_cnt];
  assign stop_req   = abort || abort_pending;
  assign handshake  = ctrl_valid && ctrl_ready;
  assign last_layer = ({1'b0, layer_cnt} == (num_layers_q - (AW+1)'(1)));
  assign last_frame = (frame_cnt == (num_frames_q - 8'd1));
  assign zero_run   = (num_layers_i == '0) || (num_frames_i == 8'd0);

  // NOTE: the descriptor table has no reset; only control state needs a known value.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy) desc_mem[cfg_addr] <= cfg_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = zero_run ? S_DONE : S_LOAD;
      S_LOAD:  state_nxt = stop_req ? S_DONE : S_ISSUE;
      // An accepted handshake wins over a same-cycle abort; the layer then runs out.
      S_ISSUE: if (handshake)     state_nxt = S_WAIT;
               else if (stop_req) state_nxt = S_DONE;
      S_WAIT:  if (ctrl_finish) begin
                 if (stop_req || (last_layer && last_frame)) state_nxt = S_DONE;
                 else                                        state_nxt = S_LOAD;
               end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    ctrl_valid = (state == S_ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_layers_q  <= '0;
      num_frames_q  <= '0;
      abort_pending <= 1'b0;
      aborted       <= 1'b0;
      layer_cnt     <= '0;
      frame_cnt     <= '0;
      w_num_o       <= '0;
      h_num_o       <= '0;
      c_num_o       <= '0;
      co_num_o      <= '0;
      shift_bias_o  <= '0;
      kernel_mode_o <= 1'b0;
      is_diff_o     <= 1'b0;
      is_first_o    <= 1'b0;
    end else begin
      if (state == S_IDLE)  abort_pending <= 1'b0;
      else if (abort)       abort_pending <= 1'b1;

      if (state != S_IDLE && state_nxt == S_DONE && stop_req) aborted <= 1'b1;

      case (state)
        S_IDLE: if (start) begin
          num_layers_q <= num_layers_i;
          num_frames_q <= num_frames_i;
          layer_cnt    <= '0;
          frame_cnt    <= '0;
          aborted      <= 1'b0;
        end
        S_LOAD: begin
          w_num_o       <= rd_desc[7:0];
          h_num_o       <= rd_desc[15:8];
          c_num_o       <= rd_desc[23:16];
          co_num_o      <= rd_desc[31:24];
          shift_bias_o  <= rd_desc[35:32];
          kernel_mode_o <= rd_desc[36];
          is_first_o    <= (frame_cnt == 8'd0);
          is_diff_o     <= rd_desc[37] && (frame_cnt != 8'd0);
        end
        S_WAIT: if (ctrl_finish && !stop_req) begin
          if (!last_layer) begin
            layer_cnt <= layer_cnt + AW'(1);
          end else if (!last_frame) begin
            layer_cnt <= '0;
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_cfg_sched.sv
// Self-checking bench for layer_cfg_sched: a forked controller model answers
// handshakes and scores each issued configuration against a table model.
`timescale 1ns/1ps
module tb_layer_cfg_sched;

  localparam int DEPTH     = 8;
  localparam int AW        = 3;
  localparam int FIN_DELAY = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [37:0]   cfg_wdata;
  logic          start;
  logic [AW:0]   num_layers_i;
  logic [7:0]    num_frames_i;
  logic          abort;
  logic          busy, done, aborted;
  logic [AW-1:0] layer_cnt;
  logic [7:0]    frame_cnt;
  logic          ctrl_valid, ctrl_ready, ctrl_finish;
  logic [7:0]    w_num_o, h_num_o, c_num_o, co_num_o;
  logic [3:0]    shift_bias_o;
  logic          kernel_mode_o, is_diff_o, is_first_o;

  typedef struct packed {
    logic [7:0]    w, h, c, co;
    logic [3:0]    sb;
    logic          km, diff, first;
    logic [AW-1:0] layer;
    logic [7:0]    frame;
  } cfg_t;

  typedef struct {
    int nl; int nf; int hs; int lc; int fc;
  } run_vec_t;

  logic [37:0] model_mem [DEPTH];
  cfg_t        exp_q [$];
  run_vec_t    vecs [6];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_hs     = 0;

  always #5 clk = ~clk;

  layer_cfg_sched #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .num_layers_i(num_layers_i), .num_frames_i(num_frames_i), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .layer_cnt(layer_cnt), .frame_cnt(frame_cnt),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl_finish(ctrl_finish),
    .w_num_o(w_num_o), .h_num_o(h_num_o), .c_num_o(c_num_o), .co_num_o(co_num_o),
    .shift_bias_o(shift_bias_o), .kernel_mode_o(kernel_mode_o),
    .is_diff_o(is_diff_o), .is_first_o(is_first_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] make_desc(input logic [7:0] w, h, c, co,
                                            input logic [3:0] sb, input logic km, diff);
    return {diff, km, sb, co, c, h, w};
  endfunction

  function automatic cfg_t dut_cfg();
    return cfg_t'({w_num_o, h_num_o, c_num_o, co_num_o, shift_bias_o, kernel_mode_o,
                   is_diff_o, is_first_o, layer_cnt, frame_cnt});
  endfunction

  function automatic cfg_t model_cfg(input int l, input int f);
    cfg_t        e;
    logic [37:0] d;
    d       = model_mem[l];
    e.w     = d[7:0];
    e.h     = d[15:8];
    e.c     = d[23:16];
    e.co    = d[31:24];
    e.sb    = d[35:32];
    e.km    = d[36];
    e.first = (f == 0);
    e.diff  = d[37] && (f != 0);
    e.layer = AW'(l);
    e.frame = 8'(f);
    return e;
  endfunction

  task automatic push_run(input int nl, input int nf);
    for (int f = 0; f < nf; f++)
      for (int l = 0; l < nl; l++) exp_q.push_back(model_cfg(l, f));
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'({busy, done, aborted, ctrl_valid, dut_cfg()}), 64'd0);
  endtask

  // Controller model: scores each accepted configuration, then finishes it later.
  task automatic responder();
    cfg_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ctrl_valid && ctrl_ready) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          check("unexpected_handshake", 64'(dut_cfg()), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("handshake_cfg", 64'(dut_cfg()), 64'(e));
        end
        @(posedge clk);
        repeat (FIN_DELAY - 1) @(posedge clk);
        #1 ctrl_finish = 1'b1;
        @(posedge clk);
        #1 ctrl_finish = 1'b0;
      end
    end
  endtask

  task automatic cfg_write(input int addr, input logic [37:0] d, input bit take);
    @(posedge clk);
    #1 cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_wdata = d;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    if (take) model_mem[addr] = d;
  endtask

  task automatic pulse_start(input int nl, input int nf);
    @(posedge clk);
    #1 start = 1'b1; num_layers_i = (AW+1)'(nl); num_frames_i = 8'(nf);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output int lat);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
    end
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ctrl_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_hs(input int target, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_hs >= target) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_and_check(input string tag, input run_vec_t v);
    bit seen;
    int lat;
    int hs0;
    push_run(v.nl, v.nf);
    hs0 = n_hs;
    pulse_start(v.nl, v.nf);
    wait_done(seen, lat);
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, "_aborted"}, 64'(aborted), 64'd0);
      check({tag, "_layer_cnt"}, 64'(layer_cnt), 64'(v.lc));
      check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(v.fc));
      if (v.nl == 0 || v.nf == 0) check({tag, "_zero_latency_le2"}, 64'(lat <= 2), 64'd1);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
      check({tag, "_busy_low"}, 64'(busy), 64'd0);
    end
    check({tag, "_handshakes"}, 64'(n_hs - hs0), 64'(v.hs));
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    bit seen;
    int lat;
    int hs0;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;
    num_layers_i = '0; num_frames_i = '0; abort = 1'b0; ctrl_ready = 1'b1; ctrl_finish = 1'b0;

    vecs[0] = '{nl: 1, nf: 1, hs: 1, lc: 0, fc: 0};
    vecs[1] = '{nl: 3, nf: 2, hs: 6, lc: 2, fc: 1};
    vecs[2] = '{nl: 8, nf: 1, hs: 8, lc: 7, fc: 0};
    vecs[3] = '{nl: 2, nf: 3, hs: 6, lc: 1, fc: 2};
    vecs[4] = '{nl: 0, nf: 5, hs: 0, lc: 0, fc: 0};
    vecs[5] = '{nl: 4, nf: 0, hs: 0, lc: 0, fc: 0};

    fork
      responder();
    join_none

    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_outputs");
    @(negedge clk) rst_n = 1'b1;

    cfg_write(0, make_desc(8'd24, 8'd8, 8'd8, 8'd8, 4'd3, 1'b1, 1'b1), 1'b1);
    for (int i = 1; i < DEPTH; i++)
      cfg_write(i, make_desc(8'(10 + i), 8'(20 + i), 8'(30 + i), 8'(40 + i),
                             4'(i), i[0], i[1]), 1'b1);

    // Single layer, single frame: exact handshake and done timing.
    push_run(1, 1);
    hs0 = n_hs;
    pulse_start(1, 1);
    @(negedge clk);
    check("s1_load_no_valid", 64'(ctrl_valid), 64'd0);
    check("s1_load_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("s1_valid_2_after_start", 64'(ctrl_valid), 64'd1);
    check("s1_first_diff_w", 64'({is_first_o, is_diff_o, w_num_o}), 64'({1'b1, 1'b0, 8'd24}));
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ctrl_finish === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("s1_finish_seen", 64'(seen), 64'd1);
    @(negedge clk);
    check("s1_done_after_finish", 64'({done, aborted}), 64'({1'b1, 1'b0}));
    @(negedge clk);
    check("s1_done_drop_busy_drop", 64'({done, busy}), 64'd0);
    check("s1_handshakes", 64'(n_hs - hs0), 64'd1);

    // Table write and start while busy must both be ignored.
    push_run(1, 1);
    hs0 = n_hs;
    pulse_start(1, 1);
    @(posedge clk);
    #1 cfg_we = 1'b1; cfg_addr = AW'(1); cfg_wdata = 38'h3F_FFFF_FFFF;
    start = 1'b1; num_layers_i = (AW+1)'(5); num_frames_i = 8'd9;
    @(posedge clk);
    #1 cfg_we = 1'b0; start = 1'b0;
    wait_done(seen, lat);
    check("busy_ign_done", 64'(seen), 64'd1);
    check("busy_ign_counters", 64'({layer_cnt, frame_cnt}), 64'd0);
    repeat (4) @(negedge clk);
    check("busy_ign_no_rerun", 64'(busy), 64'd0);
    check("busy_ign_handshakes", 64'(n_hs - hs0), 64'd1);
    exp_q.delete();

    for (int i = 0; i < 6; i++) run_and_check($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: configuration held stable while ready is low.
    ctrl_ready = 1'b0;
    model_mem[0] = model_mem[0];
    push_run(1, 1);
    hs0 = n_hs;
    pulse_start(1, 1);
    wait_valid(seen);
    check("bp_valid_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_held", 64'(ctrl_valid), 64'd1);
      if (exp_q.size() > 0) check("bp_cfg_stable", 64'(dut_cfg()), 64'(exp_q[0]));
    end
    @(posedge clk);
    #1 ctrl_ready = 1'b1;
    wait_done(seen, lat);
    check("bp_done", 64'({seen, aborted}), 64'({1'b1, 1'b0}));
    check("bp_handshakes", 64'(n_hs - hs0), 64'd1);
    exp_q.delete();

    // Abort while waiting on layer 1 of 3: layer 1 completes, layer 2 never issues.
    push_run(2, 1);
    hs0 = n_hs;
    pulse_start(3, 1);
    wait_hs(hs0 + 2, seen);
    check("abw_second_hs", 64'(seen), 64'd1);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_done(seen, lat);
    check("abw_done", 64'(seen), 64'd1);
    check("abw_aborted_layer", 64'({aborted, layer_cnt}), 64'({1'b1, AW'(1)}));
    repeat (6) @(negedge clk);
    check("abw_no_more_hs", 64'(n_hs - hs0), 64'd2);
    check("abw_idle", 64'({busy, ctrl_valid}), 64'd0);
    check("abw_queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // Abort during ISSUE with ready low: nothing accepted, done next cycle.
    ctrl_ready = 1'b0;
    hs0 = n_hs;
    pulse_start(2, 1);
    wait_valid(seen);
    check("abi_valid_seen", 64'(seen), 64'd1);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abi_done_aborted_novalid", 64'({done, aborted, ctrl_valid}), 64'({1'b1, 1'b1, 1'b0}));
    @(negedge clk);
    check("abi_busy_low", 64'(busy), 64'd0);
    ctrl_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("abi_no_handshake", 64'(n_hs - hs0), 64'd0);

    // Asynchronous reset while waiting on a layer, then a fresh run.
    push_run(2, 1);
    hs0 = n_hs;
    pulse_start(2, 1);
    wait_hs(hs0 + 1, seen);
    check("rst_first_hs", 64'(seen), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("midrun_reset_outputs");
    check("midrun_reset_counters", 64'({layer_cnt, frame_cnt}), 64'd0);
    exp_q.delete();
    repeat (6) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_and_check("post_reset", '{nl: 2, nf: 2, hs: 4, lc: 1, fc: 1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
